io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- Peripheral on the far side of the processor's external I/O pins. It supplies the processor's `read_in` word and absorbs its `write_out` word.
- Buffers inbound words from an external producer in an RX FIFO. Buffers outbound words to an external consumer in a TX FIFO.
- Both external sides use a valid/ready handshake. The processor side uses single-cycle strobes.
- Sits at top level beside the processor core; all logic is on one clock.

Parameters:
- WIDTH, 16: data word width; matches processor datapath.
- DEPTH, 4: entries per FIFO; must be a power of 2, ≥2.
- AW, log2(DEPTH): pointer width (derived).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- read_in  out  WIDTH  RX FIFO head word, driven to the processor.
- read_strobe  in  1  processor consumed `read_in` this cycle; pop RX.
- write_out  in  WIDTH  word from the processor.
- write_strobe  in  1  processor presents a valid `write_out` this cycle; push TX.
- in_data  in  WIDTH  external producer word.
- in_valid  in  1  producer has a word.
- in_ready  out  1  RX can accept.
- out_data  out  WIDTH  TX FIFO head word.
- out_valid  out  1  TX non-empty.
- out_ready  in  1  consumer accepts `out_data`.
- rx_count  out  AW+1  RX occupancy.
- tx_count  out  AW+1  TX occupancy.
- err_underflow  out  1  sticky: `read_strobe` while RX empty.
- err_overflow  out  1  sticky: `write_strobe` dropped because TX full.

Behaviour:
- Reset is synchronous (sampled at posedge while rst=1) and applies to both FIFOs.
  - Pointers and counts go to 0; both error flags go to 0.
  - Outputs: `in_ready`=0 while rst=1, 1 on the first cycle after; `out_valid`=0; `read_in`=0; `out_data`=0.
  - Stored words are not cleared. Reset asserted mid-transfer discards all buffered data; no handshake completes in a reset cycle.
- RX push: `in_valid & in_ready` at posedge writes `in_data` at the write pointer; wptr++ with mod-DEPTH wrap.
- RX ready: `in_ready` = (rx_count != DEPTH) | read_strobe.
  - Push at full is accepted when a pop occurs in the same cycle.
  - This path is combinational from `read_strobe`; the processor must drive `read_strobe` from a register.
- RX read: `read_in` = mem[rptr] when rx_count>0, else 0 (combinational from state only).
- RX pop: `read_strobe` with rx_count>0 pops; rptr++.
  - `read_strobe` with rx_count==0 sets `err_underflow`, leaves RX unchanged, and `read_in` stays 0.
- RX latency: a word pushed at edge N is visible on `read_in` after edge N (zero-bubble when empty).
- TX push: `write_strobe` writes `write_out` when tx_count<DEPTH, or when tx_count==DEPTH and `out_ready` is high (pop same cycle).
  - Otherwise the word is dropped and `err_overflow` is set. Sticky flags clear only on rst.
- TX read: `out_valid` = tx_count>0; `out_data` = mem[rptr] when valid, else 0.
- TX pop: `out_valid & out_ready` pops.
- Consumer handshake rule: once `out_valid` is 1, `out_data` holds until it is accepted.
- Count update: count' = count + push − pop, per FIFO.
  - Simultaneous push and pop keeps the count; both pointers advance.
  - Push and pop at empty: the word is stored and the pop is ignored (nothing to pop), so count becomes 1. Empty-state bypass is not permitted.
- Pointers are AW bits with natural wrap; full/empty are decided by count, not pointer compare.
- No combinational path from `in_data` to `read_in` or from `write_out` to `out_data`.

Decomposition:
- Shared package/header holds IO_WIDTH=16 and IO_DEPTH_DEFAULT=4, plus an error-bit index constant if flags are later packed into a status word.
- One natural sub-module: `sync_fifo` (WIDTH, DEPTH). It provides push/pop/full/empty/count, handles simultaneous push/pop at full, and ignores pop at empty.
  - The bridge instantiates it twice.
  - The bridge itself adds handshake glue and sticky error flags.

Test Plan:
- Reset then idle: after rst, `in_ready`=1, `out_valid`=0, `read_in`=0, rx_count=tx_count=0, both errors 0.
- RX fill/drain: push 0x1111, 0x2222, 0x3333, 0x4444 with no strobe.
  - `in_ready` drops to 0 at count 4; a fifth word 0xDEAD is held and not taken.
  - Four `read_strobe` cycles return 0x1111..0x4444 in order; 0xDEAD is then accepted.
- RX full with simultaneous push and pop: at count 4, `in_valid`=1 (0x5555) with `read_strobe`=1.
  - The push is accepted; count stays 4; the order after wrap is preserved.
- TX overflow: `out_ready`=0, five `write_strobe`s of 0xA0..0xA4. Four are stored and 0xA4 is dropped.
  - `err_overflow`=1 and stays set.
  - With `out_ready`=1, 0xA0..0xA3 drain in order and `out_valid` falls.
- Underflow: `read_strobe` with RX empty → `err_underflow`=1, `read_in`=0, rx_count stays 0.
- Reset mid-operation: rst asserted with RX=2 and TX=3 → next cycle counts are 0, `out_valid`=0, errors cleared. A subsequent push and pop behaves normally.

Source files
------------

// File: rtl/io_port_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bridge_pkg
// Description : Shared constants and types for the processor I/O port bridge.
//               IO_WIDTH          - processor datapath word width
//               IO_DEPTH_DEFAULT  - default entries per bridge FIFO
//               ERR_*_BIT         - bit positions if the sticky error flags
//                                   are later packed into a status word
// Revision    : 1.0 - initial release
// ============================================================================
package io_port_bridge_pkg;

    localparam int IO_WIDTH          = 16;
    localparam int IO_DEPTH_DEFAULT  = 4;

    localparam int ERR_UNDERFLOW_BIT = 0;
    localparam int ERR_OVERFLOW_BIT  = 1;

    // Sticky error flags, ordered so the packed value matches ERR_*_BIT.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage : io_port_bridge_pkg
`default_nettype wire

// File: rtl/io_port_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bridge_sync_fifo
// Description : Single-clock FIFO with count-based full/empty.
//               A push at full is accepted only if a pop happens in the same
//               cycle; a pop at empty is ignored (a simultaneous push at empty
//               still stores its word, giving count 1 -- no bypass).
//               The head word reads 0 while empty.
// Ports       : clock, rst        - clock, synchronous active-high reset
//               push, push_data   - write request and word
//               pop               - read request (advances head)
//               head_data         - current head word (0 when empty)
//               count             - occupancy 0..DEPTH
//               full, empty       - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bridge_sync_fifo
    import io_port_bridge_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_do;
    logic w_push_do;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_pop_do  = pop & ~w_empty;
    // At full a push only fits because the same-cycle pop frees a slot.
    assign w_push_do = push & (~w_full | w_pop_do);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_do) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_do) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push_do) - (AW+1)'(w_pop_do);
        end
    end

    // Storage is deliberately not cleared by reset; only pointers are.
    always_ff @(posedge clock) begin
        if (!rst && w_push_do) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign head_data = w_empty ? '0 : r_mem[r_rptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule : io_port_bridge_sync_fifo
`default_nettype wire

// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bridge
// Description : Peripheral beyond the processor's external I/O pins.
//               RX FIFO buffers producer words and feeds the processor's
//               read_in; TX FIFO buffers the processor's write_out words for
//               an external consumer. External sides are valid/ready, the
//               processor side uses single-cycle strobes.
// Ports       : clock, rst                     - clock, sync active-high reset
//               read_in, read_strobe           - RX head to processor / pop
//               write_out, write_strobe        - processor word / push TX
//               in_data, in_valid, in_ready    - producer handshake (RX)
//               out_data, out_valid, out_ready - consumer handshake (TX)
//               rx_count, tx_count             - FIFO occupancies
//               err_underflow, err_overflow    - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bridge
    import io_port_bridge_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    output logic [WIDTH-1:0] read_in,
    input  logic             read_strobe,
    input  logic [WIDTH-1:0] write_out,
    input  logic             write_strobe,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      rx_count,
    output logic [AW:0]      tx_count,
    output logic             err_underflow,
    output logic             err_overflow
);

    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_push;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_tx_pop;
    err_flags_t r_err;

    // A pop in the same cycle makes room at full; read_strobe must come
    // from a processor register since it feeds in_ready combinationally.
    assign in_ready  = ~rst & (~w_rx_full | read_strobe);
    assign w_rx_push = in_valid & in_ready;

    assign out_valid = ~w_tx_empty;
    assign w_tx_pop  = out_valid & out_ready;

    io_port_bridge_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (w_rx_push),
        .push_data (in_data),
        .pop       (read_strobe),
        .head_data (read_in),
        .count     (rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    io_port_bridge_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (write_strobe),
        .push_data (write_out),
        .pop       (w_tx_pop),
        .head_data (out_data),
        .count     (tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (read_strobe && w_rx_empty) begin
                r_err.underflow <= 1'b1;
            end
            // At full the write survives only when the consumer drains.
            if (write_strobe && w_tx_full && !out_ready) begin
                r_err.overflow <= 1'b1;
            end
        end
    end

    assign err_underflow = r_err.underflow;
    assign err_overflow  = r_err.overflow;

endmodule : io_port_bridge
`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bridge
// Description : Self-checking bench for io_port_bridge. Directed scenarios
//               followed by random traffic, compared every cycle against a
//               queue-based reference model of both FIFOs and the flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bridge;

    localparam int c_WIDTH = 16;
    localparam int c_DEPTH = 4;
    localparam int c_AW    = 2;

    logic               clock = 1'b0;
    logic               rst;
    logic [c_WIDTH-1:0] read_in;
    logic               read_strobe;
    logic [c_WIDTH-1:0] write_out;
    logic               write_strobe;
    logic [c_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [c_AW:0]      rx_count;
    logic [c_AW:0]      tx_count;
    logic               err_underflow;
    logic               err_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [c_WIDTH-1:0] m_rx[$];
    logic [c_WIDTH-1:0] m_tx[$];
    logic               m_unf;
    logic               m_ovf;

    io_port_bridge #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .read_in       (read_in),
        .read_strobe   (read_strobe),
        .write_out     (write_out),
        .write_strobe  (write_strobe),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    function automatic logic exp_in_ready();
        return !rst && ((m_rx.size() != c_DEPTH) || read_strobe);
    endfunction

    // Check outputs against the model, then apply this cycle's transfers.
    task automatic cycle();
        logic rdy;
        logic rx_pop;
        logic tx_pop;
        @(negedge clock);
        rdy = exp_in_ready();
        chk("in_ready",  32'(in_ready), 32'(rdy));
        chk("read_in",   32'(read_in),   (m_rx.size() > 0) ? 32'(m_rx[0]) : 32'd0);
        chk("out_valid", 32'(out_valid), 32'(m_tx.size() > 0));
        chk("out_data",  32'(out_data),  (m_tx.size() > 0) ? 32'(m_tx[0]) : 32'd0);
        chk("rx_count",  32'(rx_count),  32'(m_rx.size()));
        chk("tx_count",  32'(tx_count),  32'(m_tx.size()));
        chk("err_underflow", 32'(err_underflow), 32'(m_unf));
        chk("err_overflow",  32'(err_overflow),  32'(m_ovf));
        if (rst) begin
            m_rx.delete();
            m_tx.delete();
            m_unf = 1'b0;
            m_ovf = 1'b0;
        end else begin
            rx_pop = read_strobe && (m_rx.size() > 0);
            if (read_strobe && m_rx.size() == 0) m_unf = 1'b1;
            if (rx_pop) void'(m_rx.pop_front());
            if (in_valid && rdy) m_rx.push_back(in_data);

            tx_pop = (m_tx.size() > 0) && out_ready;
            if (write_strobe) begin
                if (m_tx.size() < c_DEPTH || out_ready) begin
                    if (tx_pop) begin
                        void'(m_tx.pop_front());
                        tx_pop = 1'b0;
                    end
                    m_tx.push_back(write_out);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (tx_pop) void'(m_tx.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        read_strobe  = 1'b0;
        write_strobe = 1'b0;
        write_out    = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
    endtask

    logic [c_WIDTH-1:0] rx_words [4];
    initial begin
        rx_words[0] = 16'h1111; rx_words[1] = 16'h2222;
        rx_words[2] = 16'h3333; rx_words[3] = 16'h4444;
    end

    initial begin
        m_unf = 1'b0;
        m_ovf = 1'b0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clock); #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();                                // idle after reset

        // RX fill, then a held fifth word
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rx_words[i];
            cycle();
        end
        in_data = 16'hDEAD;
        cycle();
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_strobe = 1'b1;
            cycle();
        end
        read_strobe = 1'b0;
        in_valid = 1'b1; in_data = 16'hDEAD;
        cycle();
        in_valid = 1'b0;

        // Refill to full, then push + pop at full
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = rx_words[i];
            cycle();
        end
        in_data = 16'h5555; read_strobe = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();    // drain incl. one underflow
        read_strobe = 1'b0;
        chk("underflow_set", 32'(err_underflow), 32'd1);
        chk("rx_empty",      32'(rx_count),      32'd0);

        // TX overflow
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write_strobe = 1'b1; write_out = 16'(16'hA0 + i);
            cycle();
        end
        write_strobe = 1'b0;
        cycle();
        chk("overflow_set", 32'(err_overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("tx_drained", 32'(out_valid), 32'd0);

        // TX push at full with simultaneous pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_strobe = 1'b1; write_out = 16'(16'hB0 + i);
            cycle();
        end
        out_ready = 1'b1; write_out = 16'hB4;
        cycle();
        write_strobe = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b0;

        // Reset mid-operation with RX=2, TX=3
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2); in_data = 16'(16'hC0 + i);
            write_strobe = 1'b1; write_out = 16'(16'hD0 + i);
            cycle();
        end
        idle_inputs();
        chk("pre_rst_rx", 32'(rx_count), 32'd2);
        chk("pre_rst_tx", 32'(tx_count), 32'd3);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hEEEE;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk("post_rst_rx", 32'(rx_count), 32'd0);
        chk("post_rst_ovf_unf", 32'({err_overflow, err_underflow}), 32'd0);
        in_valid = 1'b1; in_data = 16'h1234;
        write_strobe = 1'b1; write_out = 16'h4321;
        cycle();
        idle_inputs();
        read_strobe = 1'b1; out_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            in_valid     = $urandom_range(0, 1);
            in_data      = 16'($urandom);
            read_strobe  = ($urandom_range(0, 2) == 0);
            write_strobe = $urandom_range(0, 1);
            write_out    = 16'($urandom);
            out_ready    = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle_inputs();
        rst = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_io_port_bridge
`default_nettype wire
